// File: rtl/axis_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// axis_fifo_ctrl
// Controller that turns a single-clock dual-port RAM (registered read, one
// cycle latency) into an AXI-Stream FIFO. It owns the write/read pointers and
// the RAM write enable. It also prefetches RAM words into a 2-entry output
// buffer, so the master side can sustain one beat per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all contents (highest priority)
//   s_axis_*          slave (input) stream: tdata, tlast, tvalid, tready
//   m_axis_*          master (output) stream: tdata, tlast, tvalid, tready
//   ram_we/waddr/din  RAM write port, din = {tlast, tdata}
//   ram_raddr/dout    RAM read port, dout valid one cycle after raddr
//   level             beats held: RAM + read in flight + output buffer
// -----------------------------------------------------------------------------
module axis_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH:0]   ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH:0]   ram_dout,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  // Pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH:0] ob0_q, ob0_d;   // head of output buffer
  logic [DATA_WIDTH:0] ob1_q, ob1_d;   // second entry

  logic [ADDR_WIDTH:0] mem_cnt_s;
  logic [2:0]          inflight_s;
  logic                push_s, pop_s, issue_s;

  assign mem_cnt_s     = wptr_q - rptr_q;
  assign s_axis_tready = (mem_cnt_s != DEPTH_C) && !flush;

  // tready reads 1 during reset, so the write enable is also gated by rst_n.
  // This keeps the RAM untouched while the controller is held in reset.
  assign push_s    = s_axis_tvalid && s_axis_tready && rst_n;
  assign ram_we    = push_s;
  assign ram_waddr = wptr_q[ADDR_WIDTH-1:0];
  assign ram_din   = {s_axis_tlast, s_axis_tdata};
  assign ram_raddr = rptr_q[ADDR_WIDTH-1:0];

  assign m_axis_tvalid = (ob_cnt_q != 2'd0);
  assign m_axis_tdata  = ob0_q[DATA_WIDTH-1:0];
  assign m_axis_tlast  = ob0_q[DATA_WIDTH];
  assign pop_s         = m_axis_tvalid && m_axis_tready;

  // A read may be issued only if the word will have room when it lands.
  // pop_s is only 1 when ob_cnt_q >= 1, so the subtraction cannot underflow.
  assign inflight_s = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
  assign issue_s    = (mem_cnt_s != {(ADDR_WIDTH + 1){1'b0}}) &&
                      (inflight_s <= 3'd1) && !flush;

  assign level = {1'b0, mem_cnt_s}
               + {{(ADDR_WIDTH + 1){1'b0}}, rd_pend_q}
               + {{ADDR_WIDTH{1'b0}}, ob_cnt_q};

  // Next-state logic for the pointers, the read-pending flag and the output buffer.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_pend_d = rd_pend_q;
    ob_cnt_d  = ob_cnt_q;
    ob0_d     = ob0_q;
    ob1_d     = ob1_q;
    if (flush) begin
      wptr_d    = {(ADDR_WIDTH + 1){1'b0}};
      rptr_d    = {(ADDR_WIDTH + 1){1'b0}};
      rd_pend_d = 1'b0;
      ob_cnt_d  = 2'd0;
      ob0_d     = {(DATA_WIDTH + 1){1'b0}};
      ob1_d     = {(DATA_WIDTH + 1){1'b0}};
    end else begin
      wptr_d    = wptr_q + {{ADDR_WIDTH{1'b0}}, push_s};
      rptr_d    = rptr_q + {{ADDR_WIDTH{1'b0}}, issue_s};
      rd_pend_d = issue_s;
      // rd_pend_q=1 means ram_dout holds the word read on the previous edge.
      case ({pop_s, rd_pend_q})
        2'b10: begin
          ob0_d    = ob1_q;
          ob_cnt_d = ob_cnt_q - 2'd1;
        end
        2'b01: begin
          if (ob_cnt_q == 2'd0) begin
            ob0_d = ram_dout;
          end else begin
            ob1_d = ram_dout;
          end
          ob_cnt_d = ob_cnt_q + 2'd1;
        end
        2'b11: begin
          // The head leaves and the new word joins the tail. The count is unchanged.
          if (ob_cnt_q == 2'd2) begin
            ob0_d = ob1_q;
            ob1_d = ram_dout;
          end else begin
            ob0_d = ram_dout;
          end
        end
        default: begin
          ob_cnt_d = ob_cnt_q;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= {(ADDR_WIDTH + 1){1'b0}};
      rptr_q    <= {(ADDR_WIDTH + 1){1'b0}};
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob0_q     <= {(DATA_WIDTH + 1){1'b0}};
      ob1_q     <= {(DATA_WIDTH + 1){1'b0}};
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
    end
  end

endmodule
